// File: rtl/victim_cache.sv
// Fully associative victim buffer between a direct-mapped L1 and main memory.
// Holds dirty lines evicted from L1 and returns them on refill; lines reach memory only when displaced.
module victim_cache #(
  parameter int NUM_ENTRIES = 4,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              l1_req_valid,
  input  logic              l1_req_rw,
  input  logic [ADDR_W-1:0] l1_req_addr,
  input  logic [127:0]      l1_req_wdata,
  output logic              l1_resp_valid,
  output logic [127:0]      l1_resp_rdata,
  output logic              mem_req_valid,
  output logic              mem_req_rw,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [127:0]      mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [127:0]      mem_resp_rdata,
  output logic [15:0]       hit_count
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int TAG_W = ADDR_W - 4;

  typedef enum logic [2:0] {
    S_IDLE, S_RESP, S_MEM_RD, S_WAIT_RD, S_MEM_WB, S_WAIT_WB
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]       tag_q  [NUM_ENTRIES];
  logic [TAG_W-1:0]       tag_d  [NUM_ENTRIES];
  logic [127:0]           data_q [NUM_ENTRIES];
  logic [127:0]           data_d [NUM_ENTRIES];
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W-1:0]       tgt_q, tgt_d;
  logic                   req_rw_q, req_rw_d;
  logic [TAG_W-1:0]       req_tag_q, req_tag_d;
  logic [127:0]           req_wdata_q, req_wdata_d;
  logic [127:0]           rdata_q, rdata_d;
  logic [15:0]            hit_count_q, hit_count_d;

  logic [TAG_W-1:0] req_tag_in;
  logic             hit, free;
  logic [IDX_W-1:0] hit_idx, free_idx;
  logic             unused_addr_lsb;

  assign req_tag_in      = l1_req_addr[ADDR_W-1:4];
  assign unused_addr_lsb = ^l1_req_addr[3:0];

  // Downward scan leaves the lowest matching / lowest free index selected.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free     = 1'b0;
    free_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i] && (tag_q[i] == req_tag_in)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!valid_q[i]) begin
        free     = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    tag_d       = tag_q;
    data_d      = data_q;
    ptr_d       = ptr_q;
    tgt_d       = tgt_q;
    req_rw_d    = req_rw_q;
    req_tag_d   = req_tag_q;
    req_wdata_d = req_wdata_q;
    rdata_d     = rdata_q;
    hit_count_d = hit_count_q;
    case (state_q)
      S_IDLE: begin
        if (l1_req_valid) begin
          req_rw_d    = l1_req_rw;
          req_tag_d   = req_tag_in;
          req_wdata_d = l1_req_wdata;
          if (!l1_req_rw) begin
            if (hit) begin
              rdata_d = data_q[hit_idx];
              if (hit_count_q != 16'hFFFF) hit_count_d = hit_count_q + 16'd1;
              state_d = S_RESP;
            end else begin
              state_d = S_MEM_RD;
            end
          end else if (hit) begin
            tgt_d   = hit_idx;
            state_d = S_RESP;
          end else if (free) begin
            tgt_d   = free_idx;
            state_d = S_RESP;
          end else begin
            state_d = S_MEM_WB;
          end
        end
      end
      // Writes land in the buffer in the response cycle, so the next request sees them.
      S_RESP: begin
        if (req_rw_q) begin
          valid_d[tgt_q] = 1'b1;
          tag_d[tgt_q]   = req_tag_q;
          data_d[tgt_q]  = req_wdata_q;
        end
        state_d = S_IDLE;
      end
      S_MEM_RD: state_d = S_WAIT_RD;
      S_WAIT_RD: begin
        if (mem_resp_valid) begin
          rdata_d = mem_resp_rdata;
          state_d = S_RESP;
        end
      end
      S_MEM_WB: state_d = S_WAIT_WB;
      S_WAIT_WB: begin
        if (mem_resp_valid) begin
          tgt_d   = ptr_q;
          ptr_d   = ptr_q + 1'b1;
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      valid_q     <= '0;
      ptr_q       <= '0;
      tgt_q       <= '0;
      req_rw_q    <= 1'b0;
      req_tag_q   <= '0;
      req_wdata_q <= '0;
      rdata_q     <= '0;
      hit_count_q <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      ptr_q       <= ptr_d;
      tgt_q       <= tgt_d;
      req_rw_q    <= req_rw_d;
      req_tag_q   <= req_tag_d;
      req_wdata_q <= req_wdata_d;
      rdata_q     <= rdata_d;
      hit_count_q <= hit_count_d;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        tag_q[i]  <= tag_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

  // Valid/ready contract: each request state lasts one cycle, so pulses are single-cycle by construction.
  assign l1_resp_valid = (state_q == S_RESP);
  assign l1_resp_rdata = rdata_q;
  assign mem_req_valid = (state_q == S_MEM_RD) || (state_q == S_MEM_WB);
  assign mem_req_rw    = (state_q == S_MEM_WB);
  assign mem_req_addr  = (state_q == S_MEM_WB) ? {tag_q[ptr_q], 4'h0} :
                         (state_q == S_MEM_RD) ? {req_tag_q, 4'h0} : '0;
  assign mem_req_wdata = (state_q == S_MEM_WB) ? data_q[ptr_q] : '0;
  assign hit_count     = hit_count_q;

endmodule

// File: tb/tb_victim_cache.sv
// Directed bench for victim_cache: L1 driver tasks, a two-cycle-latency memory responder,
// and a scoreboard of expected refill data.
module tb_victim_cache;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         l1_req_valid;
  logic         l1_req_rw;
  logic [31:0]  l1_req_addr;
  logic [127:0] l1_req_wdata;
  logic         l1_resp_valid;
  logic [127:0] l1_resp_rdata;
  logic         mem_req_valid;
  logic         mem_req_rw;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_wdata;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_rdata;
  logic [15:0]  hit_count;

  int           n_checks = 0;
  int           n_pass   = 0;
  int           mem_cnt  = 0;
  logic         last_rw;
  logic [31:0]  last_addr;
  logic [127:0] last_wdata;
  logic         mem_hold = 1'b0;
  logic [127:0] exp_q[$];

  victim_cache #(.NUM_ENTRIES(4), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .l1_req_valid(l1_req_valid), .l1_req_rw(l1_req_rw),
    .l1_req_addr(l1_req_addr), .l1_req_wdata(l1_req_wdata),
    .l1_resp_valid(l1_resp_valid), .l1_resp_rdata(l1_resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .hit_count(hit_count)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n        = 1'b0;
    l1_req_valid = 1'b0;
    l1_req_rw    = 1'b0;
    l1_req_addr  = '0;
    l1_req_wdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Memory image: line L reads as {L+3, L+2, L+1, L} offset by 0x1000_0000.
  function automatic logic [127:0] block_of(input logic [31:0] a);
    logic [31:0] l;
    l = 32'h1000_0000 + {4'h0, a[31:4]};
    return {l + 32'd3, l + 32'd2, l + 32'd1, l};
  endfunction

  // Memory monitor
  initial begin
    forever begin
      @(negedge clk);
      if (mem_req_valid) begin
        mem_cnt++;
        last_rw    = mem_req_rw;
        last_addr  = mem_req_addr;
        last_wdata = mem_req_wdata;
      end
    end
  end

  // Memory responder: completes two cycles after seeing a request
  initial begin
    logic        r;
    logic [31:0] a;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req_valid && !mem_hold) begin
        r = mem_req_rw;
        a = mem_req_addr;
        repeat (2) @(negedge clk);
        mem_resp_valid = 1'b1;
        mem_resp_rdata = r ? 128'h0 : block_of(a);
        @(negedge clk);
        mem_resp_valid = 1'b0;
      end
    end
  end

  // L1 driver: lat counts cycles from the accept edge to the response pulse
  task automatic l1_txn(input string tag, input logic rw, input logic [31:0] addr,
                        input logic [127:0] wd, output logic [127:0] rd, output int lat);
    logic got;
    @(negedge clk);
    l1_req_valid = 1'b1;
    l1_req_rw    = rw;
    l1_req_addr  = addr;
    l1_req_wdata = wd;
    @(posedge clk);
    #1 l1_req_valid = 1'b0;
    lat = 0;
    rd  = '0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (l1_resp_valid) begin
        rd  = l1_resp_rdata;
        got = 1'b1;
      end
    end
    if (!got) check({tag, "_timeout"}, 128'd0, 128'd1);
  endtask

  task automatic l1_write(input string tag, input logic [31:0] addr, input logic [127:0] wd,
                          input int exp_lat, input int exp_mem);
    logic [127:0] rd;
    int lat, m0;
    m0 = mem_cnt;
    l1_txn(tag, 1'b1, addr, wd, rd, lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_memreqs"}, mem_cnt - m0, exp_mem);
  endtask

  task automatic l1_read(input string tag, input logic [31:0] addr, input logic [127:0] exp_data,
                         input int exp_lat, input int exp_mem);
    logic [127:0] rd;
    int lat, m0;
    m0 = mem_cnt;
    exp_q.push_back(exp_data);
    l1_txn(tag, 1'b0, addr, 128'h0, rd, lat);
    check({tag, "_data"}, rd, exp_q.pop_front());
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_memreqs"}, mem_cnt - m0, exp_mem);
  endtask

  localparam logic [127:0] D_CAFE = {4{32'hCAFE_BABE}};
  localparam logic [127:0] D_A    = {4{32'hAAAA_0001}};
  localparam logic [127:0] D_B    = {4{32'hBBBB_0002}};

  function automatic logic [127:0] dk(input int k);
    return {4{32'h1111_0000 + k}};
  endfunction

  initial begin
    int w;
    do_reset();
    check("rst_resp_valid", l1_resp_valid, 1'b0);
    check("rst_mem_valid", mem_req_valid, 1'b0);
    check("rst_mem_addr", mem_req_addr, 32'h0);
    check("rst_hit_count", hit_count, 16'h0);

    // Writeback then refill
    l1_write("wb_cafe", 32'h0000_0100, D_CAFE, 1, 0);
    l1_read("rd_cafe", 32'h0000_0100, D_CAFE, 1, 0);
    check("hit_count_1", hit_count, 16'd1);

    // Read miss goes to memory, no allocation
    l1_read("rd_miss_230", 32'h0000_0230, block_of(32'h0000_0230), 4, 1);
    check("miss_rw", last_rw, 1'b0);
    check("miss_addr", last_addr, 32'h0000_0230);
    check("hit_count_miss", hit_count, 16'd1);
    l1_read("rd_miss_230_again", 32'h0000_0230, block_of(32'h0000_0230), 4, 1);

    // In-place overwrite uses a single entry: three more lines fit, the fifth displaces 0x40/B
    do_reset();
    l1_write("ovw_a", 32'h40, D_A, 1, 0);
    l1_write("ovw_b", 32'h40, D_B, 1, 0);
    l1_read("ovw_rd", 32'h40, D_B, 1, 0);
    l1_write("ovw_f1", 32'h50, dk(5), 1, 0);
    l1_write("ovw_f2", 32'h60, dk(6), 1, 0);
    l1_write("ovw_f3", 32'h70, dk(7), 1, 0);
    l1_write("ovw_disp", 32'h80, dk(8), 4, 1);
    check("ovw_disp_addr", last_addr, 32'h40);
    check("ovw_disp_data", last_wdata, D_B);

    // Fill and displace in FIFO order
    do_reset();
    for (int k = 0; k < 4; k++) l1_write("fill", 32'(k * 16), dk(k), 1, 0);
    l1_write("fill_5th", 32'h40, dk(4), 4, 1);
    check("disp0_rw", last_rw, 1'b1);
    check("disp0_addr", last_addr, 32'h00);
    check("disp0_data", last_wdata, dk(0));
    l1_read("rd_displaced_00", 32'h00, block_of(32'h00), 4, 1);
    l1_read("rd_hit_40", 32'h40, dk(4), 1, 0);
    check("fill_hit_count", hit_count, 16'd1);
    l1_write("fill_6th", 32'h50, dk(5), 4, 1);
    check("disp1_addr", last_addr, 32'h10);
    check("disp1_data", last_wdata, dk(1));
    l1_read("rd_hit_20", 32'h20, dk(2), 1, 0);

    // Edge address: no aliasing with line 0
    do_reset();
    l1_write("edge_wr", 32'hFFFF_FFF0, D_A, 1, 0);
    l1_read("edge_rd_hit", 32'hFFFF_FFF0, D_A, 1, 0);
    l1_read("edge_rd_zero", 32'h0000_0000, block_of(32'h0), 4, 1);
    check("edge_miss_addr", last_addr, 32'h0);

    // Reset during WAIT_WB
    do_reset();
    for (int k = 0; k < 4; k++) l1_write("rst_fill", 32'h100 + 32'(k * 16), dk(k), 1, 0);
    mem_hold = 1'b1;
    @(negedge clk);
    l1_req_valid = 1'b1;
    l1_req_rw    = 1'b1;
    l1_req_addr  = 32'h140;
    l1_req_wdata = dk(9);
    @(posedge clk);
    #1 l1_req_valid = 1'b0;
    w = 0;
    while (!mem_req_valid && w < 10) begin
      @(negedge clk);
      w++;
    end
    check("midop_wb_seen", mem_req_valid, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midop_resp_valid", l1_resp_valid, 1'b0);
    check("midop_resp_rdata", l1_resp_rdata, 128'h0);
    check("midop_mem_valid", mem_req_valid, 1'b0);
    check("midop_mem_rw", mem_req_rw, 1'b0);
    check("midop_mem_addr", mem_req_addr, 32'h0);
    check("midop_mem_wdata", mem_req_wdata, 128'h0);
    check("midop_hit_count", hit_count, 16'h0);
    repeat (3) @(negedge clk);
    mem_hold = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    l1_read("midop_rd_100", 32'h100, block_of(32'h100), 4, 1);
    check("midop_rd_rw", last_rw, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
